alu_seq: RTL



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_iter.sv | 68 ++++++
 rtl/alu_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - OP_* : 3-bit operation codes carried on cntrl
//   - state_e : control FSM states of alu_seq
package alu_pkg;

    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_MUL   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_LSL   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   start        : latch A/B and begin a new product (ignored while running)
//   A, B         : operands, sampled on start
//   done         : high during the cycle in which the last iteration executes
//   product      : 2*WIDTH-bit product; valid while done is high and holds after
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] addend;
    logic [SHW-1:0]     cnt_q;
    logic               run_q;

    // product is the accumulator *after* the current iteration, so the
    // caller can register the final value on the same edge as the last step.
    // Once idle the addend is zero and product simply holds acc_q.
    always_comb begin
        addend = '0;
        if (run_q && b_q[cnt_q]) begin
            addend = {{WIDTH{1'b0}}, a_q} << cnt_q;
        end
        acc_d = acc_q + addend;
    end

    assign done    = run_q && (cnt_q == SHW'(WIDTH - 1));
    assign product = acc_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start && !run_q) begin
            a_q   <= A;
            b_q   <= B;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;  // wraps to 0 after the last step (WIDTH is a power of two)
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with registered result and N/Z/V/C flags.
// Single-cycle ops (pass, add, sub, and, or, xor, lsl) complete on the accept
// edge; MUL runs WIDTH iterations in alu_mul_iter.
// Ports:
//   clk, reset_n            : clock, synchronous active-low reset
//   in_valid / in_ready     : operand handshake (A, B, cntrl)
//   out_valid / out_ready   : result handshake (result + flags)
//   result, negative, zero, overflow, carry_out : registered outputs
//   busy                    : FSM is not idle (multiply in flight or waiting)
//
// Handshake: a transfer happens on a rising edge where valid && ready. Inputs
// are sampled only on that edge. in_ready depends on out_ready combinationally
// (a result draining this cycle frees the output register for the next one).
// While out_valid && !out_ready the result and flags are held unchanged.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             busy
);

    state_e state_q, state_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;

    logic             out_free;
    logic             accept;
    logic             load_alu;
    logic             load_mul;
    logic             mul_start;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;

    // ------------------------------------------------------------------
    // Single-cycle datapath. ADD and SUB share one adder; SUB feeds ~B with
    // a carry-in of 1.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             alu_c;
    logic [WIDTH-1:0] b_op;
    logic             cin;
    logic [WIDTH:0]   sum;

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        cin     = (cntrl == OP_SUB);
        b_op    = cin ? ~B : B;
        sum     = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
        case (cntrl)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                // carry into the MSB is recovered from the MSB sum bit
                alu_v   = (sum[WIDTH-1] ^ A[WIDTH-1] ^ b_op[WIDTH-1]) ^ sum[WIDTH];
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_LSL:  alu_res = A << B[SHW-1:0];
            default: alu_res = B;   // OP_PASSB; OP_MUL never loads from here
        endcase
    end

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .A       (A),
        .B       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = reset_n && (state_q == S_IDLE) && out_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cntrl == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = S_MUL;
                    end else begin
                        load_alu = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    if (out_free) begin
                        load_mul = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // the multiplier holds its final product while idle
                if (out_free) begin
                    load_mul = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register: a load wins over a drain, so drain+load keeps
    // out_valid high with the new data.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        neg_d       = neg_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        cout_d      = cout_q;
        if (load_alu) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            neg_d       = alu_res[WIDTH-1];
            zero_d      = (alu_res == '0);
            ovf_d       = alu_v;
            cout_d      = alu_c;
        end else if (load_mul) begin
            out_valid_d = 1'b1;
            result_d    = mul_product[WIDTH-1:0];
            neg_d       = mul_product[WIDTH-1];
            zero_d      = (mul_product[WIDTH-1:0] == '0);
            ovf_d       = (mul_product[2*WIDTH-1:WIDTH] != '0);
            cout_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            neg_q       <= neg_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            cout_q      <= cout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;
    assign busy      = (state_q != S_IDLE);

endmodule
